// File: rtl/afifo_pkg.sv
// Shared async-FIFO definitions: byte width and the keep-field width helper.
package afifo_pkg;

  localparam int BYTE_W = 8;

  function automatic int keep_w(input int bytes);
    return $clog2(bytes + 1);
  endfunction

endpackage

// File: rtl/afifo_byte_accum.sv
// Collects popped bytes into a partial word and assembles the output word.
// Latency: complete is combinational with the pop of the final byte; no own backpressure.
module afifo_byte_accum
  import afifo_pkg::*;
#(
  parameter int BYTES     = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       rclk,
  input  logic                       rrst_n,
  input  logic                       push,
  input  logic [BYTE_W-1:0]          din,
  input  logic                       drain,
  output logic [$clog2(BYTES)-1:0]   byte_cnt,
  output logic                       complete,
  output logic [BYTE_W*BYTES-1:0]    word
);

  localparam int CNT_W = $clog2(BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [BYTE_W*(BYTES-1)-1:0] acc;

  assign complete = push && (byte_cnt == LAST);

  // Slots are cleared whenever a word leaves, so unfilled slots read as zero.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      acc      <= '0;
      byte_cnt <= '0;
    end else if (complete || drain) begin
      acc      <= '0;
      byte_cnt <= '0;
    end else if (push) begin
      for (int i = 0; i < BYTES - 1; i++) begin
        if (byte_cnt == CNT_W'(i)) begin
          acc[i*BYTE_W +: BYTE_W] <= din;
        end
      end
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < BYTES - 1; i++) begin
      if (LSB_FIRST) begin
        word[i*BYTE_W +: BYTE_W] = acc[i*BYTE_W +: BYTE_W];
      end else begin
        word[(BYTES-1-i)*BYTE_W +: BYTE_W] = acc[i*BYTE_W +: BYTE_W];
      end
    end
    if (complete) begin
      if (LSB_FIRST) begin
        word[(BYTES-1)*BYTE_W +: BYTE_W] = din;
      end else begin
        word[BYTE_W-1:0] = din;
      end
    end
  end

endmodule

// File: rtl/afifo_word_reader.sv
// Async-FIFO read-side packer: pops bytes, emits BYTES-wide words; m_valid rises on the final pop edge.
// Backpressure: pops stall only at the last byte slot while the output is held; WRD_FLUSH_EN adds flush/m_keep.
module afifo_word_reader
  import afifo_pkg::*;
#(
  parameter int BYTES     = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                        rclk,
  input  logic                        rrst_n,
  input  logic                        empty,
  input  logic [BYTE_W-1:0]           readData,
  output logic                        rinc,
  output logic                        m_valid,
  output logic [BYTE_W*BYTES-1:0]     m_data,
  input  logic                        m_ready
`ifdef WRD_FLUSH_EN
  ,
  input  logic                        flush,
  output logic [keep_w(BYTES)-1:0]    m_keep
`endif
);

  localparam int CNT_W  = $clog2(BYTES);
  localparam int KEEP_W = keep_w(BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic                      out_free;
  logic                      flush_pend;
  logic                      emit_part;
  logic                      complete;
  logic [CNT_W-1:0]          byte_cnt;
  logic [BYTE_W*BYTES-1:0]   word;

  assign out_free = !m_valid || m_ready;
  assign rinc     = rrst_n && !empty && !((byte_cnt == LAST) && !out_free) && !flush_pend;

  afifo_byte_accum #(
    .BYTES     (BYTES),
    .LSB_FIRST (LSB_FIRST)
  ) u_accum (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .push     (rinc),
    .din      (readData),
    .drain    (emit_part),
    .byte_cnt (byte_cnt),
    .complete (complete),
    .word     (word)
  );

`ifdef WRD_FLUSH_EN
  assign emit_part = flush_pend && out_free;

  // A flush only arms if bytes remain after this edge's pop; a completing edge leaves none.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      flush_pend <= 1'b0;
    end else if (emit_part) begin
      flush_pend <= 1'b0;
    end else if (flush && !complete && (rinc || (byte_cnt != '0))) begin
      flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      m_keep <= '0;
    end else if (complete) begin
      m_keep <= KEEP_W'(BYTES);
    end else if (emit_part) begin
      m_keep <= KEEP_W'(byte_cnt);
    end
  end
`else
  assign flush_pend = 1'b0;
  assign emit_part  = 1'b0;
`endif

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (complete || emit_part) begin
      m_valid <= 1'b1;
      m_data  <= word;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
